// File: rtl/panda_pulse_pkg.sv
// Shared constants and FSM state type for the panda_pulse delay/stretch stage.
package panda_pulse_pkg;

    localparam int unsigned DELAY_MIN  = 3;
    localparam int unsigned WIDTH_MIN  = 1;
    localparam logic [31:0] MISSED_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

endpackage

// File: rtl/panda_pulse_fifo.sv
// Show-ahead synchronous FIFO holding absolute target timestamps of pending pulses.
module panda_pulse_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/panda_pulse.sv
// Re-emits each rising edge of inp_i as a pulse of programmable DELAY and WIDTH,
// queueing absolute target timestamps so closely spaced edges are all reproduced.
module panda_pulse
    import panda_pulse_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            inp_i,
    input  logic            rst_i,
    output logic            out_o,
    output logic            perr_o,
    input  logic [TS_W-1:0] DELAY,
    input  logic [TS_W-1:0] WIDTH,
    input  logic            FORCE_RST,
    output logic [31:0]     MISSED_CNT,
    output logic            ERR_OVERFLOW,
    output logic            ERR_PERIOD
);

    logic            inp_d_reg;
    logic            rst_d_reg;
    logic [TS_W-1:0] ts_reg;
    logic [TS_W-1:0] since_reg;
    logic [TS_W-1:0] wcnt_reg;
    state_t          state_reg;
    logic            out_reg;
    logic            err_ov_reg;
    logic            err_per_reg;
    logic [31:0]     missed_reg;

    logic [TS_W-1:0] delay_eff;
    logic [TS_W-1:0] width_eff;
    logic [TS_W-1:0] fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            inp_event;
    logic            blk_rst;
    logic            pop;
    logic            full_drop;
    logic            close_drop;
    logic            accept;
    logic            drop;

    assign delay_eff = (DELAY < TS_W'(DELAY_MIN)) ? TS_W'(DELAY_MIN) : DELAY;
    assign width_eff = (WIDTH == '0) ? TS_W'(WIDTH_MIN) : WIDTH;

    assign inp_event = inp_i & ~inp_d_reg;
    assign blk_rst   = (rst_i & ~rst_d_reg) | FORCE_RST;

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign pop        = !fifo_empty && (fifo_head == ts_reg) && !blk_rst;
    assign full_drop  = fifo_full && !pop;
    assign close_drop = (since_reg <= width_eff);
    assign accept     = inp_event && !blk_rst && !full_drop && !close_drop;
    assign drop       = inp_event && !blk_rst && (full_drop || close_drop);

    panda_pulse_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush     (blk_rst),
        .push      (accept),
        .push_data (ts_reg + delay_eff),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            inp_d_reg <= 1'b0;
            rst_d_reg <= 1'b0;
            ts_reg    <= '0;
            since_reg <= '1;
        end else begin
            inp_d_reg <= inp_i;
            rst_d_reg <= rst_i;
            ts_reg    <= ts_reg + TS_W'(1);
            if (blk_rst)
                since_reg <= '1;
            else if (accept)
                since_reg <= TS_W'(1);
            else if (since_reg != '1)
                since_reg <= since_reg + TS_W'(1);
        end
    end

    // A head that matches mid-pulse restarts the pulse so the queue never stalls
    // on a target that has already gone by.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= IDLE;
            out_reg   <= 1'b0;
            wcnt_reg  <= '0;
        end else if (blk_rst) begin
            state_reg <= IDLE;
            out_reg   <= 1'b0;
            wcnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        out_reg   <= 1'b1;
                        wcnt_reg  <= width_eff;
                        state_reg <= PULSE;
                    end
                end
                PULSE: begin
                    if (pop) begin
                        wcnt_reg <= width_eff;
                    end else if (wcnt_reg == TS_W'(1)) begin
                        out_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        wcnt_reg <= wcnt_reg - TS_W'(1);
                    end
                end
                default: begin
                    out_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            err_ov_reg  <= 1'b0;
            err_per_reg <= 1'b0;
            missed_reg  <= '0;
        end else if (blk_rst) begin
            err_ov_reg  <= 1'b0;
            err_per_reg <= 1'b0;
            missed_reg  <= '0;
        end else if (drop) begin
            if (full_drop)  err_ov_reg  <= 1'b1;
            if (close_drop) err_per_reg <= 1'b1;
            if (missed_reg != MISSED_MAX) missed_reg <= missed_reg + 32'd1;
        end
    end

    assign out_o        = out_reg;
    assign perr_o       = err_ov_reg | err_per_reg;
    assign ERR_OVERFLOW = err_ov_reg;
    assign ERR_PERIOD   = err_per_reg;
    assign MISSED_CNT   = missed_reg;

endmodule

// File: tb/tb_panda_pulse.sv
// Testbench for panda_pulse: directed vector table, multi-cycle reset sequences and
// randomized traffic, all checked every clock against an interval-level reference model.
module tb_panda_pulse;

    localparam int DEPTH = 4;

    logic        clk_i     = 1'b0;
    logic        reset_i   = 1'b0;
    logic        inp_i     = 1'b0;
    logic        rst_i     = 1'b0;
    logic        FORCE_RST = 1'b0;
    logic [31:0] DELAY     = '0;
    logic [31:0] WIDTH     = '0;
    logic        out_o;
    logic        perr_o;
    logic [31:0] MISSED_CNT;
    logic        ERR_OVERFLOW;
    logic        ERR_PERIOD;

    panda_pulse #(
        .FIFO_DEPTH (DEPTH),
        .TS_W       (32)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .inp_i        (inp_i),
        .rst_i        (rst_i),
        .out_o        (out_o),
        .perr_o       (perr_o),
        .DELAY        (DELAY),
        .WIDTH        (WIDTH),
        .FORCE_RST    (FORCE_RST),
        .MISSED_CNT   (MISSED_CNT),
        .ERR_OVERFLOW (ERR_OVERFLOW),
        .ERR_PERIOD   (ERR_PERIOD)
    );

    always #5 clk_i = ~clk_i;

    // Directed scenario: edges at absolute timestamps after a full reset.
    typedef struct packed {
        int delay;
        int width;
        int e0; int e1; int e2; int e3; int e4; int e5;
        int run_len;
        int exp_missed;
        int exp_ov;
        int exp_per;
        int exp_rise;
        int exp_npulses;
        int exp_nhigh;
    } vec_t;

    vec_t tbl [5];

    // Reference model: pending targets plus the interval the output is high.
    int          q[$];
    longint      out_end;
    longint      last_acc;
    bit          have_acc;
    int unsigned m_missed;
    bit          m_ov, m_per, m_inp_prev, m_rst_prev;

    int k;
    int tests = 0;
    int fails = 0;
    int npulses, nhigh, rise;
    bit out_prev_s;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        out_end    = 0;
        last_acc   = 0;
        have_acc   = 0;
        m_missed   = 0;
        m_ov       = 0;
        m_per      = 0;
        m_inp_prev = 0;
        m_rst_prev = 0;
    endfunction

    function automatic void model_edge(int kk);
        bit     ev, rev, popping, full, close;
        longint d_eff, w_eff;
        ev         = inp_i && !m_inp_prev;
        rev        = (rst_i && !m_rst_prev) || FORCE_RST;
        m_inp_prev = inp_i;
        m_rst_prev = rst_i;
        d_eff      = (DELAY < 3) ? 3 : longint'(DELAY);
        w_eff      = (WIDTH == 0) ? 1 : longint'(WIDTH);
        if (rev) begin
            q.delete();
            out_end  = 0;
            have_acc = 0;
            m_missed = 0;
            m_ov     = 0;
            m_per    = 0;
            return;
        end
        popping = (q.size() > 0) && (q[0] == kk);
        if (popping) begin
            void'(q.pop_front());
            out_end = kk + w_eff;
        end
        if (ev) begin
            full  = (q.size() == DEPTH);
            close = have_acc && ((kk - last_acc) <= w_eff);
            if (full || close) begin
                m_missed++;
                if (full)  m_ov  = 1;
                if (close) m_per = 1;
            end else begin
                q.push_back(kk + int'(d_eff));
                last_acc = kk;
                have_acc = 1;
            end
        end
    endfunction

    task automatic step();
        bit exp_out;
        @(posedge clk_i);
        model_edge(k);
        #1;
        exp_out = (k < out_end);
        tests++;
        if (out_o !== exp_out || perr_o !== (m_ov | m_per) || ERR_OVERFLOW !== m_ov ||
            ERR_PERIOD !== m_per || MISSED_CNT !== m_missed) begin
            fails++;
            $display("FAIL cycle ts=%0d: out/perr/ov/per/missed = %b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
                     k, out_o, perr_o, ERR_OVERFLOW, ERR_PERIOD, MISSED_CNT,
                     exp_out, m_ov | m_per, m_ov, m_per, m_missed);
        end
        if (out_o === 1'b1) begin
            nhigh++;
            if (!out_prev_s) begin
                npulses++;
                if (rise < 0) rise = k;
            end
        end
        out_prev_s = (out_o === 1'b1);
        k++;
    endtask

    task automatic do_reset();
        inp_i     = 0;
        rst_i     = 0;
        FORCE_RST = 0;
        reset_i   = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #3;
        reset_i    = 1;
        k          = 0;
        npulses    = 0;
        nhigh      = 0;
        rise       = -1;
        out_prev_s = 0;
    endtask

    function automatic bit hit(vec_t v, int i);
        return (i == v.e0) || (i == v.e1) || (i == v.e2) ||
               (i == v.e3) || (i == v.e4) || (i == v.e5);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             dly  wid  e0   e1   e2   e3   e4   e5  run  mis ov per rise np nhi
        tbl[0] = '{ 10,  4, 100,  -1,  -1,  -1,  -1,  -1, 130, 0, 0, 0, 110, 1, 4};
        tbl[1] = '{ 20,  2, 100, 105, 110,  -1,  -1,  -1, 150, 0, 0, 0, 120, 3, 6};
        tbl[2] = '{  1,  0,  50,  -1,  -1,  -1,  -1,  -1,  70, 0, 0, 0,  53, 1, 1};
        tbl[3] = '{100,  1, 200, 203, 206, 209, 212, 215, 330, 2, 1, 0, 300, 4, 4};
        tbl[4] = '{ 10,  8, 100, 105,  -1,  -1,  -1,  -1, 130, 1, 0, 1, 110, 1, 8};

        do_reset();
        check("reset_out", out_o, 0);
        check("reset_perr", perr_o, 0);
        check("reset_missed", MISSED_CNT, 0);
        check("reset_errs", {ERR_OVERFLOW, ERR_PERIOD}, 0);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            DELAY = tbl[t].delay;
            WIDTH = tbl[t].width;
            for (int i = 0; i < tbl[t].run_len; i++) begin
                inp_i = hit(tbl[t], i);
                step();
            end
            inp_i = 0;
            check($sformatf("v%0d_missed", t), MISSED_CNT, tbl[t].exp_missed);
            check($sformatf("v%0d_ovf", t), ERR_OVERFLOW, tbl[t].exp_ov);
            check($sformatf("v%0d_per", t), ERR_PERIOD, tbl[t].exp_per);
            check($sformatf("v%0d_perr", t), perr_o, tbl[t].exp_ov | tbl[t].exp_per);
            check($sformatf("v%0d_rise", t), rise, tbl[t].exp_rise);
            check($sformatf("v%0d_npulses", t), npulses, tbl[t].exp_npulses);
            check($sformatf("v%0d_nhigh", t), nhigh, tbl[t].exp_nhigh);
        end

        // Overflow then block reset at ts=220: queue flushed, nothing emitted later.
        do_reset();
        DELAY = 100;
        WIDTH = 1;
        for (int i = 0; i < 330; i++) begin
            inp_i = (i >= 200 && i <= 215 && (i - 200) % 3 == 0);
            rst_i = (i == 220);
            step();
            if (i == 219) begin
                check("blkrst_missed_before", MISSED_CNT, 2);
                check("blkrst_ovf_before", ERR_OVERFLOW, 1);
            end
        end
        rst_i = 0;
        check("blkrst_npulses", npulses, 0);
        check("blkrst_missed", MISSED_CNT, 0);
        check("blkrst_errs", {ERR_OVERFLOW, ERR_PERIOD}, 0);

        // Async reset in the middle of a pulse, with a period error pending.
        do_reset();
        DELAY = 10;
        WIDTH = 4;
        for (int i = 0; i <= 111; i++) begin
            inp_i = (i == 100 || i == 102);
            step();
        end
        inp_i = 0;
        check("midpulse_out_before", out_o, 1);
        check("midpulse_missed_before", MISSED_CNT, 1);
        check("midpulse_per_before", ERR_PERIOD, 1);
        #2;
        reset_i = 0;
        #1;
        check("async_out", out_o, 0);
        check("async_perr", perr_o, 0);
        check("async_missed", MISSED_CNT, 0);
        check("async_errs", {ERR_OVERFLOW, ERR_PERIOD}, 0);

        // Randomized traffic; DELAY only changes together with a forced block reset
        // so queued targets stay in time order.
        do_reset();
        DELAY = 12;
        WIDTH = 2;
        for (int i = 0; i < 3000; i++) begin
            inp_i     = ($urandom_range(0, 2) == 0);
            rst_i     = ($urandom_range(0, 99) == 0);
            FORCE_RST = ($urandom_range(0, 149) == 0);
            if (FORCE_RST)
                DELAY = $urandom_range(0, 25);
            if ($urandom_range(0, 39) == 0)
                WIDTH = $urandom_range(0, 5);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
